loop_stream_collector: RTL and testbench

- Downstream consumer of the loop value generator. Accepts its stream of DW-bit loop values over a valid/ready handshake and buffers them in a DEPTH-entry FIFO for a slower consumer.
- Accumulates per-burst statistics (value count and value sum). A burst is terminated by in_last.
- Publishes one statistics record per burst.

---
 rtl/loop_pkg.sv | 15 +
 rtl/loop_fifo.sv | 64 ++++++
 rtl/loop_stream_collector.sv | 111 +++++++++++
 tb/tb_loop_stream_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_pkg.sv
// Shared types and constants for the loop value generator/collector pair.
package loop_pkg;
    localparam int LOOP_DW  = 4;
    localparam int LOOP_CAP = 8;
    localparam int LOOP_CW  = 5;
    localparam int LOOP_SW  = 8;

    typedef logic [LOOP_DW-1:0] loop_val_t;

    typedef struct packed {
        logic [LOOP_CW-1:0] count;
        logic [LOOP_SW-1:0] sum;
        logic               ovf;
    } loop_stat_t;
endpackage

// File: rtl/loop_fifo.sv
// Synchronous DEPTH x DW FIFO with registered head and separate level counter.
module loop_fifo
    import loop_pkg::*;
#(
    parameter int DW    = LOOP_DW,
    parameter int DEPTH = LOOP_CAP,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rptr];

    // Refuse on full/empty here so callers may present raw requests.
    assign w_push = i_push && !o_full && !i_clr;
    assign w_pop  = i_pop && !o_empty && !i_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/loop_stream_collector.sv
// Buffers loop values in a FIFO and publishes saturating per-burst count/sum records.
module loop_stream_collector
    import loop_pkg::*;
#(
    parameter int DW    = LOOP_DW,
    parameter int DEPTH = LOOP_CAP,
    parameter int CW    = LOOP_CW,
    parameter int SW    = LOOP_SW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     stat_valid,
    output logic [CW-1:0]            stat_count,
    output logic [SW-1:0]            stat_sum,
    output logic                     stat_ovf
);
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_acc_fire;
    logic [CW:0]   w_cnt_ext;
    logic [SW:0]   w_sum_ext;
    logic [CW-1:0] w_cnt_nxt;
    logic [SW-1:0] w_sum_nxt;
    logic          w_ovf_nxt;

    logic [CW-1:0] r_acc_cnt;
    logic [SW-1:0] r_acc_sum;
    logic          r_acc_ovf;
    logic          r_stat_valid;
    logic [CW-1:0] r_stat_count;
    logic [SW-1:0] r_stat_sum;
    logic          r_stat_ovf;

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_acc_fire = w_push && !clr;

    loop_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (in_data),
        .o_dout  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Carry out of the widened add marks a clipped (saturated) update.
    assign w_cnt_ext = {1'b0, r_acc_cnt} + (CW+1)'(1);
    assign w_sum_ext = {1'b0, r_acc_sum} + (SW+1)'(in_data);
    assign w_cnt_nxt = w_cnt_ext[CW] ? '1 : w_cnt_ext[CW-1:0];
    assign w_sum_nxt = w_sum_ext[SW] ? '1 : w_sum_ext[SW-1:0];
    assign w_ovf_nxt = r_acc_ovf | w_cnt_ext[CW] | w_sum_ext[SW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt    <= '0;
            r_acc_sum    <= '0;
            r_acc_ovf    <= 1'b0;
            r_stat_valid <= 1'b0;
            r_stat_count <= '0;
            r_stat_sum   <= '0;
            r_stat_ovf   <= 1'b0;
        end else begin
            r_stat_valid <= 1'b0;
            if (clr) begin
                r_acc_cnt <= '0;
                r_acc_sum <= '0;
                r_acc_ovf <= 1'b0;
            end else if (w_acc_fire) begin
                if (in_last) begin
                    r_stat_valid <= 1'b1;
                    r_stat_count <= w_cnt_nxt;
                    r_stat_sum   <= w_sum_nxt;
                    r_stat_ovf   <= w_ovf_nxt;
                    r_acc_cnt    <= '0;
                    r_acc_sum    <= '0;
                    r_acc_ovf    <= 1'b0;
                end else begin
                    r_acc_cnt <= w_cnt_nxt;
                    r_acc_sum <= w_sum_nxt;
                    r_acc_ovf <= w_ovf_nxt;
                end
            end
        end
    end

    assign stat_valid = r_stat_valid;
    assign stat_count = r_stat_count;
    assign stat_sum   = r_stat_sum;
    assign stat_ovf   = r_stat_ovf;
endmodule

// File: tb/tb_loop_stream_collector.sv
// Directed self-checking bench for loop_stream_collector.
module tb_loop_stream_collector;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [3:0] level;
    logic       stat_valid;
    logic [4:0] stat_count;
    logic [7:0] stat_sum;
    logic       stat_ovf;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    loop_stream_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .stat_valid (stat_valid),
        .stat_count (stat_count),
        .stat_sum   (stat_sum),
        .stat_ovf   (stat_ovf)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tot++;
        if ({in_ready, out_valid, out_data, level} !== {1'b1, 1'b0, 4'd0, 4'd0})
            $display("FAIL reset_fifo got rdy=%b ov=%b od=%0d lv=%0d", in_ready, out_valid, out_data, level);
        else n_pass++;
        n_tot++;
        if ({stat_valid, stat_count, stat_sum, stat_ovf} !== 15'd0)
            $display("FAIL reset_stat got v=%b c=%0d s=%0d o=%b", stat_valid, stat_count, stat_sum, stat_ovf);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_burst();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(4'(i), i == 7);
            n_tot++;
            if (out_valid !== 1'b1 || out_data !== 4'(i) || stat_valid !== (i == 7))
                $display("FAIL burst_out[%0d] got ov=%b od=%0d sv=%b exp od=%0d", i, out_valid, out_data, stat_valid, i);
            else n_pass++;
        end
        tick();
        n_tot++;
        if ({stat_valid, stat_count, stat_sum, stat_ovf, out_valid} !== {1'b0, 5'd8, 8'd28, 1'b0, 1'b0})
            $display("FAIL burst_stat got v=%b c=%0d s=%0d o=%b ov=%b exp c=8 s=28", stat_valid, stat_count, stat_sum, stat_ovf, out_valid);
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            n_tot++;
            if (in_ready !== 1'b1) $display("FAIL full_ready[%0d] got %b exp 1", i, in_ready);
            else n_pass++;
            push(4'(i + 1), 1'b0);
        end
        n_tot++;
        if (in_ready !== 1'b0 || level !== 4'd8)
            $display("FAIL full_state got rdy=%b lv=%0d exp rdy=0 lv=8", in_ready, level);
        else n_pass++;
        in_valid = 1'b1;
        in_data  = 4'd9;
        tick();
        tick();
        n_tot++;
        if (level !== 4'd8 || in_ready !== 1'b0)
            $display("FAIL full_hold got lv=%0d rdy=%b exp lv=8 rdy=0", level, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tot++;
        if (level !== 4'd7 || in_ready !== 1'b1)
            $display("FAIL full_pop got lv=%0d rdy=%b exp lv=7 rdy=1", level, in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_tot++;
        if (level !== 4'd8) $display("FAIL full_accept got lv=%0d exp 8", level);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            n_tot++;
            if (out_data !== 4'(i)) $display("FAIL full_drain got %0d exp %0d", out_data, i);
            else n_pass++;
            tick();
        end
        n_tot++;
        if (out_valid !== 1'b0) $display("FAIL full_empty got ov=%b exp 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 4; i++) push(4'(i), 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 4'(i + 5);
            n_tot++;
            if (out_data !== 4'(i + 1)) $display("FAIL wrap_head[%0d] got %0d exp %0d", i, out_data, i + 1);
            else n_pass++;
            tick();
            n_tot++;
            if (level !== 4'd4) $display("FAIL wrap_level[%0d] got %0d exp 4", i, level);
            else n_pass++;
        end
        in_valid = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            n_tot++;
            if (out_data !== 4'(i)) $display("FAIL wrap_drain got %0d exp %0d", out_data, i);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(4'd15, 1'b0);
        push(4'd15, 1'b1);
        n_tot++;
        if ({stat_valid, stat_count, stat_sum, stat_ovf} !== {1'b1, 5'd21, 8'd255, 1'b1})
            $display("FAIL sat_stat got v=%b c=%0d s=%0d o=%b exp 1/21/255/1", stat_valid, stat_count, stat_sum, stat_ovf);
        else n_pass++;
        push(4'd3, 1'b1);
        n_tot++;
        if ({stat_valid, stat_count, stat_sum, stat_ovf} !== {1'b1, 5'd1, 8'd3, 1'b0})
            $display("FAIL sat_next got v=%b c=%0d s=%0d o=%b exp 1/1/3/0", stat_valid, stat_count, stat_sum, stat_ovf);
        else n_pass++;
        tick();
        n_tot++;
        if ({stat_valid, stat_count, stat_sum} !== {1'b0, 5'd1, 8'd3})
            $display("FAIL sat_hold got v=%b c=%0d s=%0d exp 0/1/3", stat_valid, stat_count, stat_sum);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(4'd5, 1'b0);
        push(4'd6, 1'b0);
        push(4'd7, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tot++;
        if (level !== 4'd0 || out_valid !== 1'b0 || stat_valid !== 1'b0)
            $display("FAIL rstmid_flush got lv=%0d ov=%b sv=%b", level, out_valid, stat_valid);
        else n_pass++;
        push(4'd1, 1'b0);
        push(4'd2, 1'b1);
        n_tot++;
        if ({stat_valid, stat_count, stat_sum, stat_ovf} !== {1'b1, 5'd2, 8'd3, 1'b0})
            $display("FAIL rstmid_stat got v=%b c=%0d s=%0d o=%b exp 1/2/3/0", stat_valid, stat_count, stat_sum, stat_ovf);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            n_tot++;
            if (out_valid !== 1'b1 || out_data !== 4'(i))
                $display("FAIL rstmid_out got ov=%b od=%0d exp %0d", out_valid, out_data, i);
            else n_pass++;
            tick();
        end
        n_tot++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_empty got ov=%b exp 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 4'd6;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_tot++;
        if ({level, out_valid, stat_valid, stat_count} !== {4'd0, 1'b0, 1'b0, 5'd0})
            $display("FAIL clr_flush got lv=%0d ov=%b sv=%b c=%0d", level, out_valid, stat_valid, stat_count);
        else n_pass++;
        push(4'd7, 1'b1);
        n_tot++;
        if ({stat_valid, stat_count, stat_sum, stat_ovf} !== {1'b1, 5'd1, 8'd7, 1'b0})
            $display("FAIL clr_next got v=%b c=%0d s=%0d o=%b exp 1/1/7/0", stat_valid, stat_count, stat_sum, stat_ovf);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_full();
        test_wrap();
        test_saturate();
        test_reset_mid();
        test_clr();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
